// File: rtl/key_pkg.sv
// Shared PS/2 scan-code constants and parser state encoding for the key scheduler.
package key_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_NULL  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } parse_state_t;

    // One-hot held-bit mask for a movement key {D,S,A,W}; zero for any other code.
    function automatic logic [3:0] move_mask(input logic [7:0] code);
        case (code)
            SC_W:    move_mask = 4'b0001;
            SC_A:    move_mask = 4'b0010;
            SC_S:    move_mask = 4'b0100;
            SC_D:    move_mask = 4'b1000;
            default: move_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small power-of-two FIFO of 8-bit key codes with synchronous flush.
module key_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & ~full & ~flush;
    assign rd_en = pop & ~empty & ~flush;
    assign dout  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/key_cmd_sched.sv
// PS/2 key parser that queues movement-key makes and releases one per frame refresh.
module key_cmd_sched
    import key_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] scan_code,
    input  logic       scan_done_tick,
    input  logic       refr_tick,
    output logic [7:0] key_code,
    output logic       cmd_valid,
    output logic       paused,
    output logic       drop_tick
);

    parse_state_t state, state_next;
    logic [3:0]   held_mv, held_mv_next;
    logic         held_p, held_p_next;
    logic         make_evt, brk_evt;
    logic [3:0]   mv;
    logic         is_p;
    logic         push_req, toggle, pop_req;
    logic [7:0]   fifo_dout;
    logic         fifo_full, fifo_empty;

    assign mv   = move_mask(scan_code);
    assign is_p = (scan_code == SC_P);

    // Parser next state, held-bit updates and queue control decisions.
    always_comb begin
        state_next   = state;
        make_evt     = 1'b0;
        brk_evt      = 1'b0;
        if (scan_done_tick) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == SC_BREAK)     state_next = ST_BRK;
                    else if (scan_code == SC_EXT)  state_next = ST_EXT;
                    else                           make_evt   = 1'b1;
                end
                ST_BRK: begin
                    brk_evt    = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_EXT: begin
                    state_next = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end

        held_mv_next = held_mv;
        held_p_next  = held_p;
        if (make_evt) begin
            held_mv_next = held_mv | mv;
            if (is_p) held_p_next = 1'b1;
        end else if (brk_evt) begin
            held_mv_next = held_mv & ~mv;
            if (is_p) held_p_next = 1'b0;
        end

        push_req = make_evt && ((mv & ~held_mv) != 4'b0000) && !paused;
        toggle   = make_evt && is_p && !held_p;
        // Pop looks at pre-cycle occupancy; a pause toggle on the same cycle wins.
        pop_req  = refr_tick && !toggle && !paused && !fifo_empty;
    end

    // Parser state, held bits, pause flag and drop pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            held_mv   <= '0;
            held_p    <= 1'b0;
            paused    <= 1'b0;
            drop_tick <= 1'b0;
        end else begin
            state     <= state_next;
            held_mv   <= held_mv_next;
            held_p    <= held_p_next;
            paused    <= paused ^ toggle;
            drop_tick <= push_req & fifo_full;
        end
    end

    // Per-frame command register: loaded from the queue head or cleared on each refresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_code  <= SC_NULL;
            cmd_valid <= 1'b0;
        end else if (refr_tick) begin
            if (pop_req) begin
                key_code  <= fifo_dout;
                cmd_valid <= 1'b1;
            end else begin
                key_code  <= SC_NULL;
                cmd_valid <= 1'b0;
            end
        end
    end

    key_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .pop     (pop_req),
        .flush   (toggle),
        .din     (scan_code),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_key_cmd_sched.sv
// Self-checking bench for key_cmd_sched: directed scenarios plus randomized traffic vs a queue model.
module tb_key_cmd_sched;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_done_tick = 1'b0;
    logic       refr_tick = 1'b0;
    logic [7:0] key_code;
    logic       cmd_valid;
    logic       paused;
    logic       drop_tick;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_held[256];
    bit         m_paused;
    bit         m_brk;
    bit         m_ext;
    logic [7:0] m_key;
    bit         m_cv;
    bit         m_drop;

    key_cmd_sched #(
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .scan_code      (scan_code),
        .scan_done_tick (scan_done_tick),
        .refr_tick      (refr_tick),
        .key_code       (key_code),
        .cmd_valid      (cmd_valid),
        .paused         (paused),
        .drop_tick      (drop_tick)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_q.delete();
        for (int i = 0; i < 256; i++) m_held[i] = 1'b0;
        m_paused = 1'b0;
        m_brk    = 1'b0;
        m_ext    = 1'b0;
        m_key    = 8'h00;
        m_cv     = 1'b0;
        m_drop   = 1'b0;
    endtask

    // One clock of behaviour: prefix tracking, make/release rules, then frame pop and queue push.
    task automatic model_step(input bit sd, input logic [7:0] b, input bit rf);
        bit is_move, do_push, do_flush, is_make;
        int pre_size;
        is_make  = 1'b0;
        do_push  = 1'b0;
        do_flush = 1'b0;
        is_move  = (b == 8'h1D) || (b == 8'h1C) || (b == 8'h1B) || (b == 8'h23);
        if (sd) begin
            if (m_ext) begin
                if (m_brk) begin
                    m_brk = 1'b0;
                    m_ext = 1'b0;
                end else if (b == 8'hF0) m_brk = 1'b1;
                else m_ext = 1'b0;
            end else if (m_brk) begin
                m_held[b] = 1'b0;
                m_brk = 1'b0;
            end else if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'hE0) m_ext = 1'b1;
            else is_make = 1'b1;
        end
        if (is_make) begin
            if (is_move && !m_held[b] && !m_paused) do_push = 1'b1;
            if (b == 8'h4D && !m_held[b]) do_flush = 1'b1;
            m_held[b] = 1'b1;
        end
        pre_size = m_q.size();
        if (rf) begin
            if (do_flush || m_paused || pre_size == 0) begin
                m_key = 8'h00;
                m_cv  = 1'b0;
            end else begin
                m_key = m_q.pop_front();
                m_cv  = 1'b1;
            end
        end
        m_drop = 1'b0;
        if (do_push) begin
            if (pre_size >= int'(DEPTH)) m_drop = 1'b1;
            else m_q.push_back(b);
        end
        if (do_flush) begin
            m_q.delete();
            m_paused = !m_paused;
        end
    endtask

    task automatic tick(input bit sd, input logic [7:0] b, input bit rf);
        scan_done_tick = sd;
        scan_code      = b;
        refr_tick      = rf;
        @(negedge clk);
        model_step(sd, b, rf);
        scan_done_tick = 1'b0;
        refr_tick      = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b, 1'b0);
    endtask

    task automatic refr();
        tick(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        scan_done_tick = 1'b0;
        refr_tick      = 1'b0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        send(8'h1D);
        refr();
        send(8'h4D);
        #3 reset_n = 1'b0;
        #1;
        if (key_code !== 8'h00) begin errors++; $display("FAIL reset_key_code got %h want 00", key_code); end
        checks++;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
        checks++;
        if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused got %b want 0", paused); end
        checks++;
        if (drop_tick !== 1'b0) begin errors++; $display("FAIL reset_drop_tick got %b want 0", drop_tick); end
        checks++;
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        send(8'h1D);
        refr();
        if (key_code !== 8'h1D || cmd_valid !== 1'b1) begin
            errors++; $display("FAIL single_pop got %h/%b want 1d/1", key_code, cmd_valid);
        end
        checks++;
        refr();
        if (key_code !== 8'h00 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL single_empty got %h/%b want 00/0", key_code, cmd_valid);
        end
        checks++;
    endtask

    task automatic test_typematic();
        do_reset();
        send(8'h1D); send(8'h1D); send(8'h1D);
        send(8'hF0); send(8'h1D);
        refr();
        if (key_code !== 8'h1D || cmd_valid !== 1'b1) begin
            errors++; $display("FAIL typematic_first got %h/%b want 1d/1", key_code, cmd_valid);
        end
        checks++;
        refr();
        if (key_code !== 8'h00 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL typematic_only_one got %h/%b want 00/0", key_code, cmd_valid);
        end
        checks++;
        send(8'h1D);
        refr();
        if (key_code !== 8'h1D || cmd_valid !== 1'b1) begin
            errors++; $display("FAIL typematic_remake got %h/%b want 1d/1", key_code, cmd_valid);
        end
        checks++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
        do_reset();
        send(8'h1D); send(8'h1C); send(8'h1B); send(8'h23);
        if (drop_tick !== 1'b0) begin errors++; $display("FAIL overflow_no_drop_yet got %b want 0", drop_tick); end
        checks++;
        send(8'hF0); send(8'h1D);
        send(8'h1D);
        if (drop_tick !== 1'b1) begin errors++; $display("FAIL overflow_drop_pulse got %b want 1", drop_tick); end
        checks++;
        tick(1'b0, 8'h00, 1'b0);
        if (drop_tick !== 1'b0) begin errors++; $display("FAIL overflow_drop_one_cycle got %b want 0", drop_tick); end
        checks++;
        for (int i = 0; i < 4; i++) begin
            refr();
            if (key_code !== exp_seq[i] || cmd_valid !== 1'b1) begin
                errors++; $display("FAIL overflow_pop%0d got %h/%b want %h/1", i, key_code, cmd_valid, exp_seq[i]);
            end
            checks++;
        end
        refr();
        if (key_code !== 8'h00 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL overflow_drained got %h/%b want 00/0", key_code, cmd_valid);
        end
        checks++;
    endtask

    task automatic test_extended();
        do_reset();
        send(8'hE0); send(8'h1D);
        send(8'hE0); send(8'hF0); send(8'h1D);
        refr();
        if (key_code !== 8'h00 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL extended_not_queued got %h/%b want 00/0", key_code, cmd_valid);
        end
        checks++;
        send(8'h1C);
        refr();
        if (key_code !== 8'h1C || cmd_valid !== 1'b1) begin
            errors++; $display("FAIL extended_then_idle got %h/%b want 1c/1", key_code, cmd_valid);
        end
        checks++;
    endtask

    task automatic test_pause();
        do_reset();
        send(8'h1D); send(8'h1C);
        send(8'h4D);
        if (paused !== 1'b1) begin errors++; $display("FAIL pause_set got %b want 1", paused); end
        checks++;
        refr();
        if (key_code !== 8'h00 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL pause_refr got %h/%b want 00/0", key_code, cmd_valid);
        end
        checks++;
        send(8'hF0); send(8'h4D); send(8'h4D);
        if (paused !== 1'b0) begin errors++; $display("FAIL pause_clear got %b want 0", paused); end
        checks++;
        refr();
        if (key_code !== 8'h00 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL pause_flushed got %h/%b want 00/0", key_code, cmd_valid);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'hF0);
        #2 reset_n = 1'b0;
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(8'h1D);
        refr();
        if (key_code !== 8'h1D || cmd_valid !== 1'b1) begin
            errors++; $display("FAIL reset_mid_seq got %h/%b want 1d/1", key_code, cmd_valid);
        end
        checks++;
    endtask

    task automatic test_coincide();
        do_reset();
        tick(1'b1, 8'h1D, 1'b1);
        if (key_code !== 8'h00 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL coincide_push_empty got %h/%b want 00/0", key_code, cmd_valid);
        end
        checks++;
        refr();
        if (key_code !== 8'h1D || cmd_valid !== 1'b1) begin
            errors++; $display("FAIL coincide_later_pop got %h/%b want 1d/1", key_code, cmd_valid);
        end
        checks++;
        send(8'h1C);
        tick(1'b1, 8'h4D, 1'b1);
        if (key_code !== 8'h00 || cmd_valid !== 1'b0 || paused !== 1'b1) begin
            errors++; $display("FAIL coincide_flush_wins got %h/%b/%b want 00/0/1", key_code, cmd_valid, paused);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [7:0] pool [8];
        logic [7:0] b;
        bit sd, rf;
        pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h4D, 8'hF0, 8'hE0, 8'h55};
        do_reset();
        for (int n = 0; n < 600; n++) begin
            sd = ($urandom_range(0, 1) == 1);
            rf = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 9) == 0) ? pool[4] : pool[$urandom_range(0, 7)];
            if (b == 8'h4D && $urandom_range(0, 1) == 0) b = pool[$urandom_range(0, 3)];
            tick(sd, b, rf);
            if (key_code !== m_key || cmd_valid !== m_cv || paused !== m_paused || drop_tick !== m_drop) begin
                errors++;
                $display("FAIL random_cycle%0d got key=%h cv=%b p=%b drop=%b want key=%h cv=%b p=%b drop=%b",
                         n, key_code, cmd_valid, paused, drop_tick, m_key, m_cv, m_paused, m_drop);
            end
            checks++;
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_single();
        test_typematic();
        test_overflow();
        test_extended();
        test_pause();
        test_reset_mid();
        test_coincide();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_cmd_sched.md
KEY_CMD_SCHED -- requirements
Module: key_cmd_sched

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued key events (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, meaning the system clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 The block SHALL have port scan_code, input, 8, meaning the PS/2 scan code byte from the receiver.
REQ-005 The block SHALL have port scan_done_tick, input, 1, meaning a one-cycle strobe that scan_code is valid.
REQ-006 The block SHALL have port refr_tick, input, 1, meaning a one-cycle frame-refresh strobe.
REQ-007 The block SHALL have port key_code, output, 8, meaning the registered code presented to the motion decoder.
REQ-008 The block SHALL have port cmd_valid, output, 1, meaning key_code holds a dequeued movement key this frame.
REQ-009 The block SHALL have port paused, output, 1, meaning the game-pause state.
REQ-010 The block SHALL have port drop_tick, output, 1, meaning a one-cycle pulse when a make event is lost to a full FIFO.

Function
REQ-011 The parser FSM SHALL have states IDLE, BRK (after 8'hF0), EXT (after 8'hE0) and EXT_BRK (after E0 then F0), and it SHALL advance only on scan_done_tick.
REQ-012 In IDLE, F0 SHALL go to BRK, E0 SHALL go to EXT, and any other byte SHALL be a make event that stays in IDLE.
REQ-013 In BRK, any byte SHALL be a release event for that code and return to IDLE.
REQ-014 In EXT, F0 SHALL go to EXT_BRK; any other byte SHALL be discarded and return to IDLE.
REQ-015 In EXT_BRK, any byte SHALL be discarded and return to IDLE; extended keys are never queued.
REQ-016 Movement keys SHALL be W=8'h1D, A=8'h1C, S=8'h1B and D=8'h23; each SHALL have a held bit, set on make and cleared on release.
REQ-017 A make of a movement key SHALL enqueue its code only if its held bit was clear (typematic repeats suppressed) and paused=0.
REQ-018 A make of P=8'h4D with its held bit clear SHALL toggle paused and flush the FIFO in the same cycle; P is never enqueued.
REQ-019 Makes and releases of all other codes SHALL be ignored.
REQ-020 If an enqueue is requested with the FIFO full, the code SHALL be dropped, drop_tick SHALL pulse the next cycle, and the held bit SHALL still be set.
REQ-021 On refr_tick with paused=0 and the FIFO non-empty, the block SHALL pop the head into key_code with cmd_valid=1 from the next cycle until the next refr_tick.
REQ-022 On refr_tick with the FIFO empty or paused=1, key_code SHALL become 8'h00 and cmd_valid SHALL become 0 from the next cycle.
REQ-023 At most one pop SHALL occur per refr_tick, so the block issues one hop per frame.
REQ-024 If push and pop occur in the same cycle, both SHALL take effect and the count SHALL be unchanged.
REQ-025 A push into an empty FIFO coinciding with refr_tick SHALL NOT be popped that cycle, since the pop uses the pre-cycle count.
REQ-026 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL range 0..FIFO_DEPTH.
REQ-027 A pause-toggle flush coinciding with refr_tick SHALL take priority, so the pop is suppressed, key_code becomes 8'h00 and cmd_valid becomes 0.

Reset
REQ-028 While reset_n=0, the outputs SHALL be key_code=8'h00, cmd_valid=0, paused=0 and drop_tick=0.
REQ-029 While reset_n=0, the FSM SHALL be in IDLE, all held bits SHALL be 0, and the FIFO SHALL be empty.
REQ-030 Reset asserted mid-sequence (e.g. after F0) SHALL discard the partial sequence and any queued events.

Structure
REQ-031 Scan-code constants (F0, E0, W, A, S, D, P, 8'h00 null) and the parser state encoding SHALL reside in a shared package key_pkg.
REQ-032 The queue SHALL be a sub-module key_fifo (parameterised depth, 8-bit data, push/pop/flush, full/empty).
REQ-033 The parser, held bits and pause logic SHALL reside in key_cmd_sched.

Verification
REQ-034 The bench SHALL check: scan 1D then refr_tick -> key_code=8'h1D, cmd_valid=1 next cycle; next refr_tick -> 8'h00, 0.
REQ-035 The bench SHALL check: scan 1D, 1D, 1D (typematic), then F0 1D -> exactly one entry queued; a later 1D make enqueues again.
REQ-036 The bench SHALL check: makes 1D, 1C, 1B, 23, 1D (with releases between repeats) and no refr_tick -> 4 queued, fifth drops with drop_tick=1 for one cycle; four refr_ticks pop 1D, 1C, 1B, 23 in order.
REQ-037 The bench SHALL check: E0 1D and E0 F0 1D -> nothing queued; FSM back in IDLE; a subsequent 1C is queued.
REQ-038 The bench SHALL check: queue 2 keys, scan 4D -> paused=1, FIFO empty, refr_tick gives key_code=8'h00; F0 4D then 4D -> paused=0.
REQ-039 The bench SHALL check: scan F0, assert reset_n=0 mid-sequence, release, scan 1D, refr_tick -> key_code=8'h1D, proving the break prefix was discarded.
